// File: rtl/dma_pkg.sv
// ============================================================================
// Module      : dma_pkg
// Description : Shared types for the DMA burst streamer: FSM states, error
//               codes and the per-burst calculation result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } dma_bs_st_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNALIGNED = 2'd1,
        ERR_SLAVE     = 2'd2
    } dma_bs_err_t;

    // Width-independent part of a burst: AXI length and bytes of the job it covers
    typedef struct packed {
        logic [7:0]  len;
        logic [32:0] covered;
    } s_dma_bs_req_t;

    function automatic logic [32:0] min33(input logic [32:0] a, input logic [32:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_burst_calc.sv
// ============================================================================
// Module      : dma_burst_calc
// Description : Combinational burst sizing: beat count limited by MAX_BEATS,
//               the BOUND_B boundary and the remaining bytes, plus edge strobes.
//               Partial strobes only with DMA_STREAMER_UNALIGNED_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 32,
    parameter int MAX_BEATS = 256,
    parameter int BOUND_B   = 4096
) (
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [31:0]         i_bytes,
    output logic [ADDR_W-1:0]   o_addr,
    output s_dma_bs_req_t       o_req,
    output logic [DATA_W/8-1:0] o_strb_first,
    output logic [DATA_W/8-1:0] o_strb_last
);

    localparam int          c_bpb     = DATA_W / 8;
    localparam int          c_sz      = $clog2(c_bpb);
    localparam logic [32:0] c_bpb33   = 33'(c_bpb);
    localparam logic [32:0] c_bound33 = 33'(BOUND_B);
    localparam logic [32:0] c_max33   = 33'(MAX_BEATS);

    logic [c_sz-1:0] w_off;
    logic [32:0]     w_addr_lo;
    logic [32:0]     w_span;
    logic [32:0]     w_need;
    logic [32:0]     w_bound;
    logic [32:0]     w_beats;
    logic [32:0]     w_avail;
    logic [32:0]     w_cov;

    assign w_off     = i_addr[c_sz-1:0];
    assign o_addr    = {i_addr[ADDR_W-1:c_sz], {c_sz{1'b0}}};
    assign w_addr_lo = 33'(o_addr);
    assign w_span    = {1'b0, i_bytes} + 33'(w_off);
    assign w_need    = (w_span + c_bpb33 - 33'd1) >> c_sz;
    assign w_bound   = (c_bound33 - (w_addr_lo & (c_bound33 - 33'd1))) >> c_sz;
    assign w_beats   = min33(min33(w_need, w_bound), c_max33);
    // The first beat starts at the byte offset, so the burst spans fewer job bytes
    assign w_avail   = (w_beats << c_sz) - 33'(w_off);
    assign w_cov     = min33({1'b0, i_bytes}, w_avail);

    assign o_req = '{len: 8'(w_beats - 33'd1), covered: w_cov};

`ifdef DMA_STREAMER_UNALIGNED_EN
    logic [32:0]       w_end_m1;
    logic [c_sz-1:0]   w_last_idx;
    logic [c_bpb-1:0]  w_first;
    logic [c_bpb-1:0]  w_last;

    assign w_end_m1   = 33'(w_off) + w_cov - 33'd1;
    assign w_last_idx = c_sz'(w_end_m1);

    always_comb begin
        w_first = '0;
        w_last  = '0;
        for (int i = 0; i < c_bpb; i++) begin
            w_first[i] = (c_sz'(i) >= w_off);
            w_last[i]  = (c_sz'(i) <= w_last_idx);
        end
    end

    assign o_strb_first = (w_beats == 33'd1) ? (w_first & w_last) : w_first;
    assign o_strb_last  = (w_beats == 33'd1) ? (w_first & w_last) : w_last;
`else
    assign o_strb_first = '1;
    assign o_strb_last  = '1;
`endif

endmodule

`default_nettype wire

// File: rtl/dma_burst_streamer.sv
// ============================================================================
// Module      : dma_burst_streamer
// Description : Splits a byte-range job into AXI bursts, tracks outstanding
//               bursts and reports errors. DMA_STREAMER_UNALIGNED_EN enables
//               arbitrary start address and length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_burst_streamer
    import dma_pkg::*;
#(
    parameter int DATA_W      = 512,
    parameter int ADDR_W      = 32,
    parameter int MAX_BEATS   = 256,
    parameter int BOUND_B     = 4096,
    parameter int MAX_OUTST   = 4,
    parameter int STREAM_TYPE = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [31:0]         bytes_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [1:0]          err_code_o,
    output logic [ADDR_W-1:0]   err_addr_o,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic [ADDR_W-1:0]   req_addr_o,
    output logic [7:0]          req_len_o,
    output logic [2:0]          req_size_o,
    output logic [DATA_W/8-1:0] req_strb_first_o,
    output logic [DATA_W/8-1:0] req_strb_last_o,
    input  logic                resp_valid_i,
    input  logic                resp_err_i
);

    localparam int c_bpb   = DATA_W / 8;
    localparam int c_sz    = $clog2(c_bpb);
    localparam int c_cnt_w = $clog2(MAX_OUTST + 1);
    localparam int c_ptr_w = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [c_cnt_w-1:0] c_outst_max = c_cnt_w'(MAX_OUTST);
    localparam logic [c_ptr_w-1:0] c_ptr_last  = c_ptr_w'(MAX_OUTST - 1);

    dma_bs_st_t         r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_bytes;
    logic [31:0]        r_covered;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [7:0]         r_req_len;
    logic [c_bpb-1:0]   r_strb_first, r_strb_last;
    logic [c_cnt_w-1:0] r_outst;
    logic [ADDR_W-1:0]  r_fifo [MAX_OUTST];
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic               r_done, r_err;
    dma_bs_err_t        r_err_code;
    logic [ADDR_W-1:0]  r_err_addr;

    logic               w_hs, w_resp, w_resp_err, w_unaligned;
    logic               w_calc_go, w_fail_align, w_done_set;
    logic [31:0]        w_bytes_rem;
    logic [ADDR_W-1:0]  w_calc_addr;
    s_dma_bs_req_t      w_calc;
    logic [c_bpb-1:0]   w_strb_first, w_strb_last;
    logic               w_unused_stream_type;

    // Both directions share the same error codes; the direction tag is informational
    assign w_unused_stream_type = (STREAM_TYPE != 0);

    dma_burst_calc #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MAX_BEATS (MAX_BEATS),
        .BOUND_B   (BOUND_B)
    ) u_calc (
        .i_addr       (r_addr),
        .i_bytes      (r_bytes),
        .o_addr       (w_calc_addr),
        .o_req        (w_calc),
        .o_strb_first (w_strb_first),
        .o_strb_last  (w_strb_last)
    );

    assign w_hs        = (r_state == ISSUE) && req_ready_i;
    // Responses with nothing outstanding (e.g. in flight across a reset) are dropped
    assign w_resp      = resp_valid_i && (r_outst != '0) && (r_state != IDLE);
    assign w_resp_err  = w_resp && resp_err_i;
    assign w_bytes_rem = r_bytes - r_covered;

`ifdef DMA_STREAMER_UNALIGNED_EN
    assign w_unaligned = 1'b0;
`else
    assign w_unaligned = (r_addr[c_sz-1:0] != '0) || (r_bytes[c_sz-1:0] != '0);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_calc_go    = 1'b0;
        w_fail_align = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (bytes_i == 32'd0) w_done_set  = 1'b1;
                    else                  w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (w_unaligned) begin
                    w_fail_align = 1'b1;
                    w_done_set   = 1'b1;
                    w_state_nxt  = IDLE;
                end else if (r_err || w_resp_err) begin
                    w_state_nxt = DRAIN;
                end else if (r_outst != c_outst_max) begin
                    w_calc_go   = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (req_ready_i) begin
                    w_state_nxt = (w_bytes_rem != 32'd0 && !r_err && !w_resp_err) ? CALC : DRAIN;
                end
            end
            DRAIN: begin
                if (r_outst == '0) begin
                    w_done_set  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr       <= '0;
            r_bytes      <= '0;
            r_covered    <= '0;
            r_req_addr   <= '0;
            r_req_len    <= '0;
            r_strb_first <= '0;
            r_strb_last  <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_err_addr   <= '0;
        end else begin
            r_done <= w_done_set;
            if (r_state == IDLE && start_i) begin
                r_addr     <= addr_i;
                r_bytes    <= bytes_i;
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
                r_err_addr <= '0;
            end
            if (w_calc_go) begin
                r_req_addr   <= w_calc_addr;
                r_req_len    <= w_calc.len;
                r_strb_first <= w_strb_first;
                r_strb_last  <= w_strb_last;
                r_covered    <= 32'(w_calc.covered);
            end
            if (w_hs) begin
                r_addr  <= r_addr + ADDR_W'(r_covered);
                r_bytes <= w_bytes_rem;
            end
            if (w_fail_align) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_UNALIGNED;
                r_err_addr <= r_addr;
            end
            // First error wins; the FIFO head is the burst this response belongs to
            if (w_resp_err && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_SLAVE;
                r_err_addr <= r_fifo[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_outst  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_hs && !w_resp)      r_outst <= r_outst + c_cnt_w'(1);
            else if (!w_hs && w_resp) r_outst <= r_outst - c_cnt_w'(1);
            if (w_hs)   r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
            if (w_resp) r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) r_fifo[r_wr_ptr] <= r_req_addr;
    end

    assign busy_o           = (r_state != IDLE);
    assign done_o           = r_done;
    assign err_o            = r_err;
    assign err_code_o       = r_err_code;
    assign err_addr_o       = r_err_addr;
    assign req_valid_o      = (r_state == ISSUE);
    assign req_addr_o       = r_req_addr;
    assign req_len_o        = r_req_len;
    assign req_size_o       = 3'(c_sz);
    assign req_strb_first_o = r_strb_first;
    assign req_strb_last_o  = r_strb_last;

endmodule

`default_nettype wire

// File: tb/tb_dma_burst_streamer.sv
// ============================================================================
// Module      : tb_dma_burst_streamer
// Description : Scoreboard bench for dma_burst_streamer (MAX_OUTST=2); covers
//               DMA_STREAMER_UNALIGNED_EN in both settings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_burst_streamer;

    localparam int DATA_W = 512;
    localparam int ADDR_W = 32;
    localparam int BPB    = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [31:0]       bytes_i = '0;
    logic              busy_o, done_o, err_o;
    logic [1:0]        err_code_o;
    logic [ADDR_W-1:0] err_addr_o;
    logic              req_valid_o;
    logic              req_ready_i = 1'b1;
    logic [ADDR_W-1:0] req_addr_o;
    logic [7:0]        req_len_o;
    logic [2:0]        req_size_o;
    logic [BPB-1:0]    req_strb_first_o, req_strb_last_o;
    logic              resp_valid_i = 1'b0;
    logic              resp_err_i = 1'b0;

    always #5 clk = ~clk;

    dma_burst_streamer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BEATS(256),
        .BOUND_B(4096), .MAX_OUTST(2), .STREAM_TYPE(0)
    ) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .addr_i(addr_i), .bytes_i(bytes_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
        .err_addr_o(err_addr_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_addr_o(req_addr_o), .req_len_o(req_len_o), .req_size_o(req_size_o),
        .req_strb_first_o(req_strb_first_o), .req_strb_last_o(req_strb_last_o),
        .resp_valid_i(resp_valid_i), .resp_err_i(resp_err_i)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [63:0] sf;
        logic [63:0] sl;
    } req_t;

    typedef struct packed {
        logic        err;
        logic [1:0]  code;
        logic [31:0] addr;
    } done_t;

    localparam logic [63:0] ONES = {64{1'b1}};

    req_t  exp_req[$];
    done_t exp_done[$];
    req_t  mr;
    done_t md;
    int checks = 0, failures = 0, issued = 0, dones = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every request handshake and done pulse
    always @(negedge clk) begin
        if (rstn && req_valid_o && req_ready_i) begin
            issued++;
            if (exp_req.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL req_unexpected actual_addr=%h required=none", req_addr_o);
            end else begin
                mr = exp_req.pop_front();
                check("req_addr", 64'(req_addr_o), 64'(mr.addr));
                check("req_len", 64'(req_len_o), 64'(mr.len));
                check("req_strb_first", req_strb_first_o, mr.sf);
                check("req_strb_last", req_strb_last_o, mr.sl);
            end
        end
        if (rstn && done_o) begin
            dones++;
            if (exp_done.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected actual=1 required=0");
            end else begin
                md = exp_done.pop_front();
                check("done_err", 64'(err_o), 64'(md.err));
                check("done_code", 64'(err_code_o), 64'(md.code));
                check("done_err_addr", 64'(err_addr_o), 64'(md.addr));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        addr_i  = a;
        bytes_i = b;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic resp(input logic e);
        resp_valid_i = 1'b1;
        resp_err_i   = e;
        tick(1);
        resp_valid_i = 1'b0;
        resp_err_i   = 1'b0;
    endtask

    task automatic wait_issued(input int target, input int budget);
        int n = 0;
        while (issued < target && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (issued < target) begin
            failures++;
            $display("FAIL wait_issued actual=%0d required=%0d", issued, target);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (dones < target && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (dones < target) begin
            failures++;
            $display("FAIL wait_done actual=%0d required=%0d", dones, target);
        end
    endtask

    task automatic respond_n(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            wait_issued(base + k + 1, 200);
            tick(2);
            resp(1'b0);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic [7:0] l,
                            input logic [63:0] sf, input logic [63:0] sl);
        exp_req.push_back('{addr: a, len: l, sf: sf, sl: sl});
    endtask

    task automatic push_done(input logic e, input logic [1:0] c, input logic [31:0] a);
        exp_done.push_back('{err: e, code: c, addr: a});
    endtask

    initial begin
        int base, d0;

        // Reset state
        tick(3);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_valid", 64'(req_valid_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_req_addr", 64'(req_addr_o), 64'd0);
        check("rst_size", 64'(req_size_o), 64'd6);
        rstn = 1'b1;
        tick(1);

        // 16 KB from 0: the 4 KB boundary limits each burst to 64 beats
        base = issued;
        for (int k = 0; k < 4; k++) push_req(32'(k * 4096), 8'd63, ONES, ONES);
        push_done(1'b0, 2'd0, 32'h0);
        start_job(32'h0, 32'd16384);
        check("busy_running", 64'(busy_o), 64'd1);
        respond_n(base, 4);
        wait_done(dones + 1, 100);
        check("idle_after_job", 64'(busy_o), 64'd0);

        // 256 B at 0xFC0: split at 0x1000
        base = issued;
        d0 = dones;
        push_req(32'hFC0, 8'd0, ONES, ONES);
        push_req(32'h1000, 8'd2, ONES, ONES);
        push_done(1'b0, 2'd0, 32'h0);
        start_job(32'hFC0, 32'd256);
        respond_n(base, 2);
        wait_done(d0 + 1, 100);

        // Unaligned start
        base = issued;
        d0 = dones;
`ifdef DMA_STREAMER_UNALIGNED_EN
        push_req(32'h1000, 8'd1, 64'hFFFF_FFFF_FFFF_FFE0, 64'h0000_01FF_FFFF_FFFF);
        push_done(1'b0, 2'd0, 32'h0);
        start_job(32'h1005, 32'd100);
        respond_n(base, 1);
        wait_done(d0 + 1, 100);
`else
        push_done(1'b1, 2'd1, 32'h1005);
        start_job(32'h1005, 32'd100);
        tick(1);
        check("align_done_latency", 64'(done_o), 64'd1);
        check("align_err_code", 64'(err_code_o), 64'd1);
        tick(3);
        check("align_err_sticky", 64'(err_o), 64'd1);
        check("align_no_request", 64'(issued - base), 64'd0);
`endif

        // Zero-length job: done one cycle after start, error cleared
        d0 = dones;
        push_done(1'b0, 2'd0, 32'h0);
        start_job(32'h40, 32'd0);
        check("zero_done", 64'(done_o), 64'd1);
        check("zero_err_clear", 64'(err_o), 64'd0);
        check("zero_busy", 64'(busy_o), 64'd0);
        tick(2);

        // Outstanding limit: 5 bursts, no responses -> only 2 issue
        base = issued;
        d0 = dones;
        for (int k = 0; k < 5; k++) push_req(32'(k * 4096), 8'd63, ONES, ONES);
        push_done(1'b0, 2'd0, 32'h0);
        start_job(32'h0, 32'd20480);
        tick(40);
        check("outst_stall_count", 64'(issued - base), 64'd2);
        check("outst_stall_valid", 64'(req_valid_o), 64'd0);
        check("outst_stall_busy", 64'(busy_o), 64'd1);
        respond_n(base, 5);
        wait_done(d0 + 1, 100);

        // Slave error on the 2nd burst while 2nd and 3rd are outstanding
        base = issued;
        d0 = dones;
        for (int k = 0; k < 3; k++) push_req(32'h10000 + 32'(k * 4096), 8'd63, ONES, ONES);
        push_done(1'b1, 2'd2, 32'h11000);
        start_job(32'h10000, 32'd16384);
        wait_issued(base + 2, 100);
        tick(2);
        resp(1'b0);
        wait_issued(base + 3, 100);
        tick(2);
        resp(1'b1);
        tick(10);
        check("err_no_new_issue", 64'(issued - base), 64'd3);
        check("err_wait_last", 64'(dones - d0), 64'd0);
        resp(1'b0);
        wait_done(d0 + 1, 100);
        tick(2);
        check("err_sticky_after_done", 64'(err_o), 64'd1);

        // Request held stable while stalled, then reset mid-ISSUE
        req_ready_i = 1'b0;
        d0 = dones;
        start_job(32'h20000, 32'd8192);
        tick(4);
        check("hold_valid", 64'(req_valid_o), 64'd1);
        check("hold_addr", 64'(req_addr_o), 64'h20000);
        tick(3);
        check("hold_addr_later", 64'(req_addr_o), 64'h20000);
        check("hold_len", 64'(req_len_o), 64'd63);
        rstn = 1'b0;
        tick(2);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_valid", 64'(req_valid_o), 64'd0);
        check("midrst_addr", 64'(req_addr_o), 64'd0);
        rstn = 1'b1;
        req_ready_i = 1'b1;
        resp(1'b0);
        tick(2);
        check("midrst_no_done", 64'(dones - d0), 64'd0);

        base = issued;
        push_req(32'h40, 8'd0, ONES, ONES);
        push_done(1'b0, 2'd0, 32'h0);
        start_job(32'h40, 32'd64);
        respond_n(base, 1);
        wait_done(d0 + 1, 100);
        tick(3);

        check("scoreboard_req_empty", 64'(exp_req.size()), 64'd0);
        check("scoreboard_done_empty", 64'(exp_done.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
